// File: rtl/magnitude_compare_sequencer_if.sv
// Bundles the requester handshake, the result bus and the slice path to the
// external 2-bit comparator. Signal suffixes are from the sequencer's side.
interface magnitude_compare_sequencer_if #(
    parameter int WIDTH = 8
);
    // requester side
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic             gt_o;
    logic             eq_o;
    logic             lt_o;
    logic             err_o;

    // comparator slice side
    logic [1:0]       slice_a_o;
    logic [1:0]       slice_b_o;
    logic             slice_gt_i;
    logic             slice_eq_i;
    logic             slice_lt_i;

    modport slave (
        input  start_i, a_i, b_i, slice_gt_i, slice_eq_i, slice_lt_i,
        output busy_o, done_o, gt_o, eq_o, lt_o, err_o, slice_a_o, slice_b_o
    );

    modport master (
        output start_i, a_i, b_i, slice_gt_i, slice_eq_i, slice_lt_i,
        input  busy_o, done_o, gt_o, eq_o, lt_o, err_o, slice_a_o, slice_b_o
    );
endinterface

// File: rtl/magnitude_compare_sequencer.sv
// Walks an external 2-bit comparator slice across two WIDTH-bit operands,
// MSB pair first, stopping at the first unequal slice.
module magnitude_compare_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    magnitude_compare_sequencer_if.slave  bus
);
    localparam int NSL  = WIDTH / 2;
    localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;

    // Per-slice views of the captured operands, selected by idx below.
    logic [1:0] pair_a [NSL];
    logic [1:0] pair_b [NSL];

    generate
        for (genvar gi = 0; gi < NSL; gi++) begin : g_pair
            assign pair_a[gi] = opa_q[2*gi +: 2];
            assign pair_b[gi] = opb_q[2*gi +: 2];
        end
    endgenerate

    logic [1:0] cur_a;
    logic [1:0] cur_b;

    always_comb begin
        cur_a = 2'b00;
        cur_b = 2'b00;
        for (int i = 0; i < NSL; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_a = pair_a[i];
                cur_b = pair_b[i];
            end
        end
    end

    logic slice_onehot;

    always_comb begin
        unique case ({bus.slice_gt_i, bus.slice_eq_i, bus.slice_lt_i})
            3'b100, 3'b010, 3'b001: slice_onehot = 1'b1;
            default:                slice_onehot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    opa_d   = bus.a_i;
                    opb_d   = bus.b_i;
                    idx_d   = IDX_TOP;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A malformed comparator answer takes priority over any verdict bit.
                if (!slice_onehot) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus.slice_gt_i) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (bus.slice_lt_i) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o    = (state_q != IDLE);
    assign bus.done_o    = (state_q == DONE);
    assign bus.slice_a_o = (state_q == RUN) ? cur_a : 2'b00;
    assign bus.slice_b_o = (state_q == RUN) ? cur_b : 2'b00;
    assign bus.gt_o      = gt_q;
    assign bus.eq_o      = eq_q;
    assign bus.lt_o      = lt_q;
    assign bus.err_o     = err_q;

endmodule
